mem_arbiter: RTL and testbench

- Shares the single backing-memory request/response port between the instruction cache (reads only) and the data cache (reads and masked writes).
- Sits between the two cache miss handlers and the external memory model.
- Serialises traffic: at most one transaction is outstanding at any time.
- Uses round-robin grant between the two caches, with a fixed response tag per owner.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 22 ++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data cache memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AddrBitsDefault  = 28;
  localparam int unsigned DataBitsDefault  = 128;
  localparam int unsigned MaskBitsDefault  = 16;
  localparam int unsigned TagBitsDefault   = 5;
  localparam int unsigned ReadBeatsDefault = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWdata = 2'd2,
    StResp  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnerIc = 1'b0,
    OwnerDc = 1'b1
  } owner_e;

  localparam int unsigned TagIc = 0;
  localparam int unsigned TagDc = 1;

  function automatic int unsigned owner_tag(owner_e owner);
    return (owner == OwnerDc) ? TagDc : TagIc;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin picker; on a tie the requester other than last_grant wins.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic       grant_valid,
  output owner_e     grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = OwnerIc;
    case (req)
      2'b01:   grant_id = OwnerIc;
      2'b10:   grant_id = OwnerDc;
      2'b11:   grant_id = (last_grant == OwnerIc) ? OwnerDc : OwnerIc;
      default: grant_id = OwnerIc;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises icache reads and dcache reads/writes onto one memory port,
// one transaction outstanding, round-robin between the two caches.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = AddrBitsDefault,
  parameter int unsigned DATA_BITS  = DataBitsDefault,
  parameter int unsigned MASK_BITS  = MaskBitsDefault,
  parameter int unsigned TAG_BITS   = TagBitsDefault,
  parameter int unsigned READ_BEATS = ReadBeatsDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ic_req_valid,
  output logic                 ic_req_ready,
  input  logic [ADDR_BITS-1:0] ic_req_addr,
  output logic                 ic_resp_valid,
  input  logic                 dc_req_valid,
  output logic                 dc_req_ready,
  input  logic                 dc_req_rw,
  input  logic [ADDR_BITS-1:0] dc_req_addr,
  input  logic                 dc_req_data_valid,
  output logic                 dc_req_data_ready,
  input  logic [DATA_BITS-1:0] dc_req_data_bits,
  input  logic [MASK_BITS-1:0] dc_req_data_mask,
  output logic                 dc_resp_valid,
  output logic [DATA_BITS-1:0] resp_data,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic                 mem_req_rw,
  output logic [ADDR_BITS-1:0] mem_req_addr,
  output logic [TAG_BITS-1:0]  mem_req_tag,
  output logic                 mem_req_data_valid,
  input  logic                 mem_req_data_ready,
  output logic [DATA_BITS-1:0] mem_req_data_bits,
  output logic [MASK_BITS-1:0] mem_req_data_mask,
  input  logic                 mem_resp_valid,
  input  logic [TAG_BITS-1:0]  mem_resp_tag,
  input  logic [DATA_BITS-1:0] mem_resp_data
);

  localparam int unsigned CntBits = $clog2(READ_BEATS + 1);
  localparam logic [CntBits-1:0] LastBeat = CntBits'(READ_BEATS - 1);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_grant_q, last_grant_d;
  logic [CntBits-1:0] beat_cnt_q, beat_cnt_d;

  logic                 grant_valid;
  owner_e               grant_id;
  logic                 own_valid;
  logic                 own_rw;
  logic [ADDR_BITS-1:0] own_addr;
  logic [TAG_BITS-1:0]  own_tag;
  logic                 resp_hit;

  rr_arbiter2 u_rr (
    .req         ({dc_req_valid, ic_req_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign own_valid = (owner_q == OwnerDc) ? dc_req_valid : ic_req_valid;
  assign own_rw    = (owner_q == OwnerDc) ? dc_req_rw : 1'b0;
  assign own_addr  = (owner_q == OwnerDc) ? dc_req_addr : ic_req_addr;
  assign own_tag   = TAG_BITS'(owner_tag(owner_q));
  assign resp_hit  = mem_resp_valid && (mem_resp_tag == own_tag);
  assign resp_data = mem_resp_data;

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    last_grant_d       = last_grant_q;
    beat_cnt_d         = beat_cnt_q;
    ic_req_ready       = 1'b0;
    dc_req_ready       = 1'b0;
    dc_req_data_ready  = 1'b0;
    ic_resp_valid      = 1'b0;
    dc_resp_valid      = 1'b0;
    mem_req_valid      = 1'b0;
    mem_req_rw         = 1'b0;
    mem_req_addr       = '0;
    mem_req_tag        = '0;
    mem_req_data_valid = 1'b0;
    mem_req_data_bits  = '0;
    mem_req_data_mask  = '0;

    case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d      = grant_id;
          last_grant_d = grant_id;
          state_d      = StReq;
        end
      end
      StReq: begin
        // Grant is held here even if the owner drops valid; no preemption.
        mem_req_valid = own_valid;
        if (own_valid) begin
          mem_req_rw   = own_rw;
          mem_req_addr = own_addr;
          mem_req_tag  = own_tag;
        end
        ic_req_ready = (owner_q == OwnerIc) && mem_req_ready;
        dc_req_ready = (owner_q == OwnerDc) && mem_req_ready;
        if (own_valid && mem_req_ready) begin
          if (own_rw) begin
            state_d = StWdata;
          end else begin
            state_d    = StResp;
            beat_cnt_d = '0;
          end
        end
      end
      StWdata: begin
        mem_req_data_valid = dc_req_data_valid;
        dc_req_data_ready  = mem_req_data_ready;
        if (dc_req_data_valid) begin
          mem_req_data_bits = dc_req_data_bits;
          mem_req_data_mask = dc_req_data_mask;
          if (mem_req_data_ready) begin
            state_d = StIdle;
          end
        end
      end
      StResp: begin
        if (resp_hit) begin
          ic_resp_valid = (owner_q == OwnerIc);
          dc_resp_valid = (owner_q == OwnerDc);
          beat_cnt_d    = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LastBeat) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerIc;
      last_grant_q <= OwnerIc;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays both caches and the memory.
module tb_mem_arbiter;

  localparam int AB = 28;
  localparam int DB = 128;
  localparam int MB = 16;
  localparam int TB = 5;
  localparam int RB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [AB-1:0] ic_req_addr;
  logic          dc_req_valid, dc_req_ready, dc_req_rw, dc_resp_valid;
  logic [AB-1:0] dc_req_addr;
  logic          dc_req_data_valid, dc_req_data_ready;
  logic [DB-1:0] dc_req_data_bits;
  logic [MB-1:0] dc_req_data_mask;
  logic [DB-1:0] resp_data;
  logic          mem_req_valid, mem_req_ready, mem_req_rw;
  logic [AB-1:0] mem_req_addr;
  logic [TB-1:0] mem_req_tag;
  logic          mem_req_data_valid, mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [MB-1:0] mem_req_data_mask;
  logic          mem_resp_valid;
  logic [TB-1:0] mem_resp_tag;
  logic [DB-1:0] mem_resp_data;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .MASK_BITS(MB), .TAG_BITS(TB), .READ_BEATS(RB)
  ) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag),
    .mem_resp_data(mem_resp_data)
  );

  int total = 0;
  int bad = 0;

  // Reference model: who was granted last, and what each cache is asking for.
  bit            last_who;
  logic [AB-1:0] req_addr[2];
  bit            req_rw[2];
  logic [DB-1:0] wbits;
  logic [MB-1:0] wmask;

  function automatic bit pick(input bit pend_ic, input bit pend_dc);
    if (pend_ic && pend_dc) return !last_who;
    return pend_dc;
  endfunction

  task automatic raise(input bit who, input bit rw, input logic [AB-1:0] a,
                       input logic [DB-1:0] bits, input logic [MB-1:0] mask);
    req_addr[who] = a;
    req_rw[who]   = who ? rw : 1'b0;
    if (who) begin
      dc_req_valid = 1'b1;
      dc_req_rw    = rw;
      dc_req_addr  = a;
      if (rw) begin
        wbits             = bits;
        wmask             = mask;
        dc_req_data_valid = 1'b1;
        dc_req_data_bits  = bits;
        dc_req_data_mask  = mask;
      end
    end else begin
      ic_req_valid = 1'b1;
      ic_req_addr  = a;
    end
  endtask

  // Acts as memory for one transaction owned by 'who'. bp < 0: random ready,
  // else ready held low for the first bp cycles the request is visible.
  task automatic serve(input bit who, input int bp, input bit stray, input int stop_beats,
                       output int wait_n);
    int seen = 0;
    int n = 0;
    int got = 0;
    int kind;
    bit fired = 0;
    logic [DB-1:0] d;
    logic [TB-1:0] stray_tag;
    wait_n   = -1;
    last_who = who;
    while (!fired && n < 40) begin
      mem_req_ready = (bp < 0) ? ($urandom_range(0, 2) != 0) : (seen >= bp);
      @(negedge clk);
      total++;
      if (mem_req_data_valid !== 1'b0) begin
        bad++; $display("FAIL req_data_valid got=%b want=0", mem_req_data_valid);
      end
      if (mem_req_valid === 1'b1) begin
        if (seen == 0) wait_n = n;
        seen++;
        total++;
        if (mem_req_tag !== TB'(who)) begin
          bad++; $display("FAIL req_tag got=%0d want=%0d", mem_req_tag, who);
        end
        total++;
        if (mem_req_addr !== req_addr[who]) begin
          bad++; $display("FAIL req_addr got=%h want=%h", mem_req_addr, req_addr[who]);
        end
        total++;
        if (mem_req_rw !== req_rw[who]) begin
          bad++; $display("FAIL req_rw got=%b want=%b", mem_req_rw, req_rw[who]);
        end
        total++;
        if ({dc_req_ready, ic_req_ready} !== (who ? {mem_req_ready, 1'b0}
                                                  : {1'b0, mem_req_ready})) begin
          bad++; $display("FAIL req_ready got=%b%b owner=%0d", dc_req_ready, ic_req_ready, who);
        end
        fired = mem_req_ready;
      end else begin
        total++;
        if ({dc_req_ready, ic_req_ready, mem_req_addr, mem_req_tag, mem_req_rw} !== '0) begin
          bad++; $display("FAIL idle_req_outputs got=%b%b %h %h want=0", dc_req_ready,
                          ic_req_ready, mem_req_addr, mem_req_tag);
        end
      end
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (!fired) begin
      bad++; $display("FAIL req_timeout got=no_handshake want=handshake");
    end
    mem_req_ready = 1'b0;
    if (who) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;

    if (req_rw[who]) begin
      fired = 0;
      n = 0;
      while (!fired && n < 40) begin
        mem_req_data_ready = (bp < 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        mem_resp_valid     = 1'b1;
        mem_resp_tag       = TB'(1);
        mem_resp_data      = {4{$urandom()}};
        @(negedge clk);
        total++;
        if ({mem_req_valid, mem_req_data_valid} !== 2'b01) begin
          bad++; $display("FAIL wdata_valid got=%b%b want=01", mem_req_valid, mem_req_data_valid);
        end
        total++;
        if (mem_req_data_bits !== wbits || mem_req_data_mask !== wmask) begin
          bad++; $display("FAIL wdata_fwd got=%h/%h want=%h/%h", mem_req_data_bits,
                          mem_req_data_mask, wbits, wmask);
        end
        total++;
        if (dc_req_data_ready !== mem_req_data_ready) begin
          bad++; $display("FAIL wdata_ready got=%b want=%b", dc_req_data_ready,
                          mem_req_data_ready);
        end
        total++;
        if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
          bad++; $display("FAIL write_resp got=%b%b want=00", ic_resp_valid, dc_resp_valid);
        end
        fired = mem_req_data_ready;
        @(posedge clk); #1;
        n++;
      end
      total++;
      if (!fired) begin
        bad++; $display("FAIL wdata_timeout got=no_handshake want=handshake");
      end
      dc_req_data_valid  = 1'b0;
      mem_req_data_ready = 1'b0;
      mem_resp_valid     = 1'b0;
    end else begin
      n = 0;
      while (got < stop_beats && n < 60) begin
        kind = $urandom_range(0, 3);
        if (!stray && kind == 3) kind = 1;
        if (stray && n == 0) kind = 3;
        stray_tag      = TB'($urandom_range(1, 31)) ^ TB'(who);
        d              = {4{$urandom()}};
        mem_resp_valid = (kind != 0);
        mem_resp_tag   = (kind == 3) ? stray_tag : TB'(who);
        mem_resp_data  = d;
        @(negedge clk);
        total++;
        if ({dc_resp_valid, ic_resp_valid} !== {(kind == 1 || kind == 2) && who,
                                                 (kind == 1 || kind == 2) && !who}) begin
          bad++; $display("FAIL resp_valid got=%b%b kind=%0d owner=%0d", dc_resp_valid,
                          ic_resp_valid, kind, who);
        end
        total++;
        if (resp_data !== d || mem_req_valid !== 1'b0) begin
          bad++; $display("FAIL resp_data got=%h/%b want=%h/0", resp_data, mem_req_valid, d);
        end
        if (kind == 1 || kind == 2) got++;
        @(posedge clk); #1;
        n++;
      end
      total++;
      if (got < stop_beats) begin
        bad++; $display("FAIL resp_timeout got=%0d want=%0d", got, stop_beats);
      end
      mem_resp_valid = 1'b0;
    end

    // Once complete, a matching beat must be ignored: the arbiter is back in IDLE.
    if (req_rw[who] || stop_beats >= RB) begin
      mem_resp_valid = 1'b1;
      mem_resp_tag   = TB'(who);
      @(negedge clk);
      total++;
      if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
        bad++; $display("FAIL extra_beat got=%b%b want=00", ic_resp_valid, dc_resp_valid);
      end
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic check_quiet(input string name);
    @(negedge clk);
    total++;
    if ({ic_req_ready, dc_req_ready, dc_req_data_ready, ic_resp_valid, dc_resp_valid,
         mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, mem_req_data_valid,
         mem_req_data_bits, mem_req_data_mask} !== '0) begin
      bad++; $display("FAIL %s got=%b%b%b%b%b%b addr=%h tag=%h want=all_zero", name,
                      ic_req_ready, dc_req_ready, dc_req_data_ready, ic_resp_valid,
                      dc_resp_valid, mem_req_valid, mem_req_addr, mem_req_tag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset_outputs");
    reset    = 1'b0;
    last_who = 1'b0;
    check_quiet("post_reset_outputs");
  endtask

  task automatic test_tie_alternation();
    int w;
    bit who;
    raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
    raise(1'b1, 1'b0, AB'($urandom()), '0, '0);
    who = pick(ic_req_valid, dc_req_valid);
    serve(who, -1, 1'b0, RB, w);
    who = pick(ic_req_valid, dc_req_valid);
    serve(who, -1, 1'b0, RB, w);
    raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
    raise(1'b1, 1'b0, AB'($urandom()), '0, '0);
    who = pick(ic_req_valid, dc_req_valid);
    serve(who, -1, 1'b0, RB, w);
    serve(pick(ic_req_valid, dc_req_valid), -1, 1'b0, RB, w);
  endtask

  task automatic test_ic_read();
    int w;
    raise(1'b0, 1'b0, 28'h0000100, '0, '0);
    serve(1'b0, 0, 1'b0, RB, w);
    total++;
    if (w != 1) begin
      bad++; $display("FAIL ic_req_latency got=%0d want=1", w);
    end
  endtask

  task automatic test_dc_write();
    int w;
    raise(1'b1, 1'b1, 28'h0000200, 128'hDEADBEEF, 16'h000F);
    serve(1'b1, 0, 1'b0, RB, w);
  endtask

  task automatic test_stray_tag();
    int w;
    for (int i = 0; i < 2; i++) begin
      raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
      serve(1'b0, 0, 1'b1, RB, w);
    end
  endtask

  task automatic test_back_pressure();
    int w;
    raise(1'b1, 1'b0, 28'h0ABCDE0, '0, '0);
    serve(1'b1, 5, 1'b0, RB, w);
  endtask

  task automatic test_reset_mid();
    int w;
    raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
    serve(1'b0, 0, 1'b0, 2, w);
    reset = 1'b1;
    @(posedge clk); #1;
    reset          = 1'b0;
    last_who       = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_tag   = '0;
    mem_resp_data  = {4{$urandom()}};
    for (int i = 0; i < 3; i++) check_quiet("after_mid_reset");
    mem_resp_valid = 1'b0;
    raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
    serve(1'b0, -1, 1'b0, RB, w);
  endtask

  task automatic test_random();
    int w;
    bit rw;
    for (int i = 0; i < 14; i++) begin
      if (!ic_req_valid && $urandom_range(0, 1) == 1)
        raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
      if (!dc_req_valid && $urandom_range(0, 1) == 1) begin
        rw = $urandom_range(0, 1) == 1;
        raise(1'b1, rw, AB'($urandom()), {4{$urandom()}}, MB'($urandom()));
      end
      if (!ic_req_valid && !dc_req_valid) raise(1'b0, 1'b0, AB'($urandom()), '0, '0);
      serve(pick(ic_req_valid, dc_req_valid), -1, 1'b1, RB, w);
    end
    while (ic_req_valid || dc_req_valid) serve(pick(ic_req_valid, dc_req_valid), -1, 1'b1, RB, w);
  endtask

  initial begin
    reset = 1'b1;
    {ic_req_valid, dc_req_valid, dc_req_rw, dc_req_data_valid} = '0;
    ic_req_addr        = '0;
    dc_req_addr        = '0;
    dc_req_data_bits   = '0;
    dc_req_data_mask   = '0;
    mem_req_ready      = 1'b0;
    mem_req_data_ready = 1'b0;
    mem_resp_valid     = 1'b0;
    mem_resp_tag       = '0;
    mem_resp_data      = '0;
    test_reset();
    test_tie_alternation();
    test_ic_read();
    test_dc_write();
    test_stray_tag();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
